baud_gen_frac: RTL and testbench
================================

// Module: baud_gen_frac
// PURPOSE
//  Fractional-N UART baud tick generator, successor to baud_gen.
//  Produces an oversampled rx_tick and a bit-rate tx_tick from independent rx and tx
//  divider paths. Adds a fractional divisor, glitch-free divisor reload, enable, and
//  rx phase resync on start-bit detect. Sits between the bus config regs and uart_rx/uart_tx.
// PARAMETERS
//  INT_W     11   width of integer divisor dvsr_int
//  FRAC_W    4    width of fractional divisor dvsr_frac (units of 1/2^FRAC_W cycle)
//  OVS       16   oversample ratio: rx_tick periods per tx_tick (>=2)
//  DEF_DVSR  2    integer divisor after reset (fraction resets to 0)
// PORTS
//  clk        in   1       system clock
//  reset      in   1       synchronous, active-high reset
//  en         in   1       1 = generate ticks; 0 = both paths cleared and held
//  dvsr_int   in   INT_W   integer divisor D; 0 treated as 1
//  dvsr_frac  in   FRAC_W  fractional divisor F
//  cfg_load   in   1       1-cycle pulse: capture dvsr_int/dvsr_frac into pending regs
//  rx_resync  in   1       1-cycle pulse: restart rx path phase (start-bit edge)
//  rx_tick    out  1       1-cycle pulse, average period D+F/2^FRAC_W cycles
//  tx_tick    out  1       1-cycle pulse, average period OVS*(D+F/2^FRAC_W) cycles
// BEHAVIOUR
//  Reset: rx_tick=0, tx_tick=0; counters, accumulators, ovs count = 0.
//   Pending and active divisors = {DEF_DVSR, 0}.
//  Each path has cnt (INT_W), acc (FRAC_W), carry bit, and its own active divisor.
//  - Period length = D_act + carry. carry = 0 after reset, resync or en=0.
//  - Wrap when cnt == D_act-1+carry. At wrap: cnt<=0; tick reg <=1 next cycle.
//  - Also at wrap: {carry,acc} <= acc + F_act; D_act/F_act <= pending.
//  - New divisor takes effect on the period after the wrap.
//  - Otherwise cnt<=cnt+1 and tick<=0. Ticks are registered, high for exactly 1 cycle.
//  - First rx_tick is high exactly D cycles after the first edge sampling en=1.
//  Tx path: same divider, plus ovs_cnt 0..OVS-1 advanced on each tx-path wrap.
//   tx_tick <= 1 on the wrap where ovs_cnt==OVS-1; ovs_cnt then returns to 0.
//   First tx_tick is OVS*D cycles after enable (F=0).
//  Fractional: F=0 gives a fixed period D. F=2^(FRAC_W-1) gives periods D,D,D+1,D,D+1,...
//  cfg_load: pending <= inputs on that edge; last load before a wrap wins.
//   If en=0, active regs of both paths also load directly.
//  rx_resync: rx cnt, acc, carry <= 0 and rx_tick <= 0 that cycle.
//   rx active <= pending. Next rx_tick is D_new cycles later.
//   Tx path is unaffected.
//  Priorities, per path: reset > en=0 > rx_resync > wrap.
//   rx_resync on a wrap cycle suppresses that tick.
//   cfg_load with rx_resync on the same edge: the rx path uses the new value immediately.
//  en=0: cnt, acc, carry, ovs_cnt cleared; ticks 0. Pending and active divisors kept.
//  Mid-operation reset: all state back to reset values on that edge.
//   Ticks low from the next cycle.
//  Widths: cnt compare uses D_act-1+carry in INT_W+1 bits, so D=max with carry=1
//   must not overflow. acc wraps mod 2^FRAC_W.
// TESTING
//  1 reset, en=1, D=2, F=0, OVS=16 -> rx_tick every 2 cycles;
//    tx_tick every 32 cycles, coincident with every 16th rx_tick.
//  2 D=5, F=8 -> rx periods 5,5,6,5,6,...; rx_tick #1 to #33 spans exactly 176 cycles.
//  3 D=10 running, cfg_load D=3 at cnt=4 -> current period ends at 10, following periods 3.
//  4 D=8, rx_resync 3 cycles after an rx_tick -> next rx_tick 8 cycles after resync.
//    tx_tick spacing stays 128 cycles.
//  5 en=0 for 20 cycles mid-stream -> no ticks; re-enable -> rx_tick after exactly D cycles.
//    reset mid-period -> outputs 0, divisor back to DEF_DVSR.
//  6 D=0, F=0 -> rx_tick high every cycle; tx_tick every OVS cycles.
//    D=2^INT_W-1, F=15 -> no overflow, periods D or D+1.

Source files
------------

// File: rtl/baud_gen_frac_if.sv
// Configuration and tick bus between the UART config registers (master)
// and the fractional baud generator (slave).
interface baud_gen_frac_if #(
  parameter int INT_W  = 11,
  parameter int FRAC_W = 4
) ();
  logic              en;
  logic [INT_W-1:0]  dvsr_int;
  logic [FRAC_W-1:0] dvsr_frac;
  logic              cfg_load;
  logic              rx_resync;
  logic              rx_tick;
  logic              tx_tick;

  modport master (
    output en, dvsr_int, dvsr_frac, cfg_load, rx_resync,
    input  rx_tick, tx_tick
  );

  modport slave (
    input  en, dvsr_int, dvsr_frac, cfg_load, rx_resync,
    output rx_tick, tx_tick
  );
endinterface

// File: rtl/baud_gen_frac.sv
// Fractional-N UART baud tick generator: independent rx (oversample) and tx (bit)
// divider paths with glitch-free divisor reload, enable and rx phase resync.
module baud_gen_frac #(
  parameter int INT_W    = 11,
  parameter int FRAC_W   = 4,
  parameter int OVS      = 16,
  parameter int DEF_DVSR = 2
) (
  input  logic           clk,
  input  logic           reset,
  baud_gen_frac_if.slave bus
);
  localparam int                OVS_W    = $clog2(OVS);
  localparam logic [OVS_W-1:0]  OVS_LAST = OVS_W'(OVS - 1);
  localparam logic [INT_W-1:0]  DEF_INT  = INT_W'(DEF_DVSR);
  localparam logic [INT_W:0]    ONE_X    = {{INT_W{1'b0}}, 1'b1};

  // Last cnt value of a period: D-1+carry, one bit wider so D=max with carry cannot overflow.
  function automatic logic [INT_W:0] wrap_point(input logic [INT_W-1:0] d, input logic c);
    logic [INT_W:0] d_eff;
    d_eff = (d == {INT_W{1'b0}}) ? ONE_X : {1'b0, d};
    return d_eff - ONE_X + {{INT_W{1'b0}}, c};
  endfunction

  logic [INT_W-1:0]  pend_int_q, pend_int_d;
  logic [FRAC_W-1:0] pend_frac_q, pend_frac_d;

  logic [INT_W-1:0]  rx_int_q, rx_int_d, rx_cnt_q, rx_cnt_d;
  logic [FRAC_W-1:0] rx_frac_q, rx_frac_d, rx_acc_q, rx_acc_d;
  logic              rx_carry_q, rx_carry_d, rx_tick_q, rx_tick_d, rx_wrap_s;

  logic [INT_W-1:0]  tx_int_q, tx_int_d, tx_cnt_q, tx_cnt_d;
  logic [FRAC_W-1:0] tx_frac_q, tx_frac_d, tx_acc_q, tx_acc_d;
  logic              tx_carry_q, tx_carry_d, tx_tick_q, tx_tick_d, tx_wrap_s;
  logic [OVS_W-1:0]  ovs_q, ovs_d;

  assign bus.rx_tick = rx_tick_q;
  assign bus.tx_tick = tx_tick_q;

  always_comb begin
    if (bus.cfg_load) begin
      pend_int_d  = bus.dvsr_int;
      pend_frac_d = bus.dvsr_frac;
    end else begin
      pend_int_d  = pend_int_q;
      pend_frac_d = pend_frac_q;
    end
  end

  // Rx path: en=0 beats resync beats wrap; resync on the same edge as cfg_load takes the new value.
  always_comb begin
    rx_wrap_s  = ({1'b0, rx_cnt_q} == wrap_point(rx_int_q, rx_carry_q));
    rx_int_d   = rx_int_q;
    rx_frac_d  = rx_frac_q;
    rx_cnt_d   = rx_cnt_q;
    rx_acc_d   = rx_acc_q;
    rx_carry_d = rx_carry_q;
    rx_tick_d  = 1'b0;
    if (!bus.en || bus.rx_resync) begin
      rx_cnt_d   = {INT_W{1'b0}};
      rx_acc_d   = {FRAC_W{1'b0}};
      rx_carry_d = 1'b0;
      if (bus.cfg_load) begin
        rx_int_d  = bus.dvsr_int;
        rx_frac_d = bus.dvsr_frac;
      end else if (bus.en) begin
        rx_int_d  = pend_int_q;
        rx_frac_d = pend_frac_q;
      end else begin
        rx_int_d  = rx_int_q;
        rx_frac_d = rx_frac_q;
      end
    end else if (rx_wrap_s) begin
      rx_cnt_d               = {INT_W{1'b0}};
      {rx_carry_d, rx_acc_d} = {1'b0, rx_acc_q} + {1'b0, rx_frac_q};
      rx_int_d               = pend_int_q;
      rx_frac_d              = pend_frac_q;
      rx_tick_d              = 1'b1;
    end else begin
      rx_cnt_d = rx_cnt_q + INT_W'(1);
    end
  end

  // Tx path: same divider, tx_tick only on the wrap that closes an OVS group.
  always_comb begin
    tx_wrap_s  = ({1'b0, tx_cnt_q} == wrap_point(tx_int_q, tx_carry_q));
    tx_int_d   = tx_int_q;
    tx_frac_d  = tx_frac_q;
    tx_cnt_d   = tx_cnt_q;
    tx_acc_d   = tx_acc_q;
    tx_carry_d = tx_carry_q;
    ovs_d      = ovs_q;
    tx_tick_d  = 1'b0;
    if (!bus.en) begin
      tx_cnt_d   = {INT_W{1'b0}};
      tx_acc_d   = {FRAC_W{1'b0}};
      tx_carry_d = 1'b0;
      ovs_d      = {OVS_W{1'b0}};
      if (bus.cfg_load) begin
        tx_int_d  = bus.dvsr_int;
        tx_frac_d = bus.dvsr_frac;
      end else begin
        tx_int_d  = tx_int_q;
        tx_frac_d = tx_frac_q;
      end
    end else if (tx_wrap_s) begin
      tx_cnt_d               = {INT_W{1'b0}};
      {tx_carry_d, tx_acc_d} = {1'b0, tx_acc_q} + {1'b0, tx_frac_q};
      tx_int_d               = pend_int_q;
      tx_frac_d              = pend_frac_q;
      if (ovs_q == OVS_LAST) begin
        ovs_d     = {OVS_W{1'b0}};
        tx_tick_d = 1'b1;
      end else begin
        ovs_d     = ovs_q + OVS_W'(1);
        tx_tick_d = 1'b0;
      end
    end else begin
      tx_cnt_d = tx_cnt_q + INT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_int_q  <= DEF_INT;
      pend_frac_q <= {FRAC_W{1'b0}};
      rx_int_q    <= DEF_INT;
      rx_frac_q   <= {FRAC_W{1'b0}};
      rx_cnt_q    <= {INT_W{1'b0}};
      rx_acc_q    <= {FRAC_W{1'b0}};
      rx_carry_q  <= 1'b0;
      rx_tick_q   <= 1'b0;
      tx_int_q    <= DEF_INT;
      tx_frac_q   <= {FRAC_W{1'b0}};
      tx_cnt_q    <= {INT_W{1'b0}};
      tx_acc_q    <= {FRAC_W{1'b0}};
      tx_carry_q  <= 1'b0;
      tx_tick_q   <= 1'b0;
      ovs_q       <= {OVS_W{1'b0}};
    end else begin
      pend_int_q  <= pend_int_d;
      pend_frac_q <= pend_frac_d;
      rx_int_q    <= rx_int_d;
      rx_frac_q   <= rx_frac_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_acc_q    <= rx_acc_d;
      rx_carry_q  <= rx_carry_d;
      rx_tick_q   <= rx_tick_d;
      tx_int_q    <= tx_int_d;
      tx_frac_q   <= tx_frac_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_acc_q    <= tx_acc_d;
      tx_carry_q  <= tx_carry_d;
      tx_tick_q   <= tx_tick_d;
      ovs_q       <= ovs_d;
    end
  end
endmodule

// File: tb/tb_baud_gen_frac.sv
// Self-checking bench for baud_gen_frac: tick times are predicted from the closed-form
// period rule T(n) = n*D + floor((n-1)*F/2^FRAC_W) measured from the first enabled edge.
module tb_baud_gen_frac;
  localparam int INT_W = 11;
  localparam int FW    = 4;
  localparam int OVS   = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   rxq[$];
  int   txq[$];

  baud_gen_frac_if #(.INT_W(INT_W), .FRAC_W(FW)) bus ();

  baud_gen_frac #(.INT_W(INT_W), .FRAC_W(FW), .OVS(OVS), .DEF_DVSR(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // A tick seen at the negedge with cyc=k rose on posedge number k-1.
  always @(negedge clk) begin
    if (bus.rx_tick === 1'b1) rxq.push_back(cyc);
    if (bus.tx_tick === 1'b1) txq.push_back(cyc);
  end

  function automatic int t_of(input int n, input int d, input int f);
    int de;
    de = (d == 0) ? 1 : d;
    return n * de + ((n - 1) * f) / (1 << FW);
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic configure(input int d, input int f);
    @(negedge clk);
    bus.en        = 1'b0;
    bus.dvsr_int  = INT_W'(d);
    bus.dvsr_frac = FW'(f);
    bus.cfg_load  = 1'b1;
    @(negedge clk);
    bus.cfg_load  = 1'b0;
    rxq.delete();
    txq.delete();
  endtask

  task automatic start(output int base);
    bus.en = 1'b1;
    base   = cyc;
  endtask

  task automatic wait_first_rx(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (rxq.size() > 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL wait_rx_tick: no rx_tick within bound, required one");
    end
  endtask

  task automatic test_reset();
    int base;
    bus.en = 1'b0; bus.cfg_load = 1'b0; bus.rx_resync = 1'b0;
    bus.dvsr_int = '0; bus.dvsr_frac = '0;
    reset = 1'b1;
    cycles(3);
    checks++;
    if (bus.rx_tick !== 1'b0 || bus.tx_tick !== 1'b0) begin
      failures++; $display("FAIL reset_ticks: rx=%b tx=%b required 0 0", bus.rx_tick, bus.tx_tick);
    end
    bus.en = 1'b1;
    cycles(4);
    checks++;
    if (rxq.size() != 0 || txq.size() != 0) begin
      failures++; $display("FAIL reset_over_en: rx ticks=%0d tx ticks=%0d required 0 0", rxq.size(), txq.size());
    end
    reset = 1'b0;
    base  = cyc;
    rxq.delete(); txq.delete();
    cycles(70);
    checks++;
    if (rxq.size() < 8 || txq.size() < 2) begin
      failures++; $display("FAIL default_counts: rx=%0d tx=%0d required >=8 >=2", rxq.size(), txq.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (rxq[i] != base + 2 * (i + 1)) begin
          failures++; $display("FAIL default_rx[%0d]: got %0d required %0d", i, rxq[i] - base, 2 * (i + 1));
        end
      end
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (txq[m] != base + 32 * (m + 1) || rxq[16 * (m + 1) - 1] != txq[m]) begin
          failures++; $display("FAIL default_tx[%0d]: got %0d required %0d coincident with rx", m, txq[m] - base, 32 * (m + 1));
        end
      end
    end
  endtask

  task automatic test_fractional();
    int base, d, f;
    for (int it = 0; it < 5; it++) begin
      d = (it == 0) ? 5 : int'($urandom_range(1, 12));
      f = (it == 0) ? 8 : int'($urandom_range(0, 15));
      configure(d, f);
      start(base);
      cycles(560);
      checks++;
      if (rxq.size() < 40 || txq.size() < 2) begin
        failures++; $display("FAIL frac_counts D=%0d F=%0d: rx=%0d tx=%0d required >=40 >=2", d, f, rxq.size(), txq.size());
        continue;
      end
      for (int i = 0; i < 40; i++) begin
        checks++;
        if (rxq[i] != base + t_of(i + 1, d, f)) begin
          failures++; $display("FAIL frac_rx D=%0d F=%0d #%0d: got %0d required %0d", d, f, i + 1, rxq[i] - base, t_of(i + 1, d, f));
          break;
        end
      end
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (txq[m] != base + t_of(OVS * (m + 1), d, f)) begin
          failures++; $display("FAIL frac_tx D=%0d F=%0d #%0d: got %0d required %0d", d, f, m + 1, txq[m] - base, t_of(OVS * (m + 1), d, f));
        end
      end
      if (it == 0) begin
        checks++;
        if (rxq[32] - rxq[0] != 176) begin
          failures++; $display("FAIL frac_span_1_33: got %0d required 176", rxq[32] - rxq[0]);
        end
      end
    end
  endtask

  task automatic test_reload();
    int base, o;
    bit ok;
    configure(10, 0);
    start(base);
    wait_first_rx(ok);
    if (!ok) return;
    o = rxq[0];
    checks++;
    if (o != base + 10) begin
      failures++; $display("FAIL reload_first: got %0d required 10", o - base);
    end
    while (cyc < o + 4) @(negedge clk);
    bus.dvsr_int = INT_W'(3);
    bus.cfg_load = 1'b1;
    @(negedge clk);
    bus.cfg_load = 1'b0;
    cycles(20);
    checks++;
    if (rxq.size() < 4) begin
      failures++; $display("FAIL reload_count: got %0d required >=4", rxq.size());
    end else begin
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (rxq[i] != o + 10 + 3 * (i - 1)) begin
          failures++; $display("FAIL reload_rx[%0d]: got %0d required %0d", i, rxq[i] - o, 10 + 3 * (i - 1));
        end
      end
    end
  endtask

  task automatic test_resync();
    int base, o, r, r2, k;
    bit ok;
    configure(8, 0);
    start(base);
    wait_first_rx(ok);
    if (!ok) return;
    o = rxq[0];
    r = o + 2;
    while (cyc < r) @(negedge clk);
    bus.rx_resync = 1'b1;
    @(negedge clk);
    bus.rx_resync = 1'b0;
    while (cyc < base + 270) @(negedge clk);
    checks++;
    if (rxq.size() < 3 || txq.size() < 2) begin
      failures++; $display("FAIL resync_counts: rx=%0d tx=%0d required >=3 >=2", rxq.size(), txq.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (rxq[i] != r + 1 + 8 * i) begin
          failures++; $display("FAIL resync_rx[%0d]: got %0d required %0d after resync", i, rxq[i] - r - 1, 8 * i);
        end
      end
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (txq[m] != base + 128 * (m + 1)) begin
          failures++; $display("FAIL resync_tx[%0d]: got %0d required %0d", m, txq[m] - base, 128 * (m + 1));
        end
      end
    end
    r2 = cyc;
    bus.dvsr_int  = INT_W'(4);
    bus.cfg_load  = 1'b1;
    bus.rx_resync = 1'b1;
    @(negedge clk);
    bus.cfg_load  = 1'b0;
    bus.rx_resync = 1'b0;
    cycles(12);
    k = 0;
    for (int i = 0; i < rxq.size(); i++) begin
      if (rxq[i] > r2 && k < 2) begin
        checks++;
        if (rxq[i] != r2 + 1 + 4 * (k + 1)) begin
          failures++; $display("FAIL resync_load[%0d]: got %0d required %0d", k, rxq[i] - r2 - 1, 4 * (k + 1));
        end
        k++;
      end
    end
    checks++;
    if (k != 2) begin
      failures++; $display("FAIL resync_load_count: got %0d required 2", k);
    end
  endtask

  task automatic test_enable_reset();
    int base, d, c, b, late, k;
    d = int'($urandom_range(3, 9));
    configure(d, 0);
    start(base);
    cycles(50);
    bus.en = 1'b0;
    c = cyc;
    cycles(20);
    late = 0;
    foreach (rxq[i]) if (rxq[i] > c) late++;
    foreach (txq[i]) if (txq[i] > c) late++;
    checks++;
    if (late != 0) begin
      failures++; $display("FAIL disabled_ticks: got %0d required 0", late);
    end
    bus.en = 1'b1;
    b = cyc;
    cycles(3 * d + 2);
    k = 0;
    for (int i = 0; i < rxq.size(); i++) begin
      if (rxq[i] > b && k < 2) begin
        checks++;
        if (rxq[i] != b + d * (k + 1)) begin
          failures++; $display("FAIL reenable_rx[%0d]: got %0d required %0d", k, rxq[i] - b, d * (k + 1));
        end
        k++;
      end
    end
    checks++;
    if (k != 2) begin
      failures++; $display("FAIL reenable_count: got %0d required 2", k);
    end
    cycles(d / 2);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.rx_tick !== 1'b0 || bus.tx_tick !== 1'b0) begin
      failures++; $display("FAIL midreset_ticks: rx=%b tx=%b required 0 0", bus.rx_tick, bus.tx_tick);
    end
    cycles(2);
    reset = 1'b0;
    b = cyc;
    rxq.delete();
    cycles(10);
    checks++;
    if (rxq.size() < 2 || rxq[0] != b + 2 || rxq[1] != b + 4) begin
      failures++; $display("FAIL midreset_default: got %0d ticks, first at %0d, required at 2 and 4",
                           rxq.size(), (rxq.size() > 0) ? rxq[0] - b : -1);
    end
  endtask

  task automatic test_boundary();
    int base;
    configure(0, 0);
    start(base);
    cycles(40);
    checks++;
    if (rxq.size() < 32 || txq.size() < 2) begin
      failures++; $display("FAIL d0_counts: rx=%0d tx=%0d required >=32 >=2", rxq.size(), txq.size());
    end else begin
      for (int i = 0; i < 32; i++) begin
        checks++;
        if (rxq[i] != base + 1 + i) begin
          failures++; $display("FAIL d0_rx[%0d]: got %0d required %0d", i, rxq[i] - base, i + 1);
          break;
        end
      end
      checks++;
      if (txq[0] != base + OVS || txq[1] != base + 2 * OVS) begin
        failures++; $display("FAIL d0_tx: got %0d,%0d required %0d,%0d", txq[0] - base, txq[1] - base, OVS, 2 * OVS);
      end
    end
    configure(2047, 15);
    start(base);
    cycles(6200);
    checks++;
    if (rxq.size() < 3) begin
      failures++; $display("FAIL dmax_count: got %0d required >=3", rxq.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (rxq[i] != base + t_of(i + 1, 2047, 15)) begin
          failures++; $display("FAIL dmax_rx[%0d]: got %0d required %0d", i, rxq[i] - base, t_of(i + 1, 2047, 15));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fractional();
    test_reload();
    test_resync();
    test_enable_reset();
    test_boundary();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
